led_status_arbiter: RTL and testbench
=====================================

# led_status_arbiter

Converts raw board status (link, DHCP, packet activity, ADC overload, TX) into one LED display mode and drives the `on`/`slow_flash`/`fast_flash`/`vary` inputs of the downstream LED flasher. It sits directly upstream of that flasher, one instance per front-panel LED. It stretches single-cycle events to human-visible durations, resolves competing requests by fixed priority, and enforces a minimum dwell per mode so the flasher's blink pattern is never chopped.

## Interface
- `CLOCK_SPEED`, 25_000_000: clock frequency in Hz; the ms prescale is `CLOCK_SPEED/1000`, which must be ≥2.
- `ACT_HOLD_MS`, 50: stretch for an `activity` pulse, in ms.
- `OVL_HOLD_MS`, 500: stretch for an `overload` pulse, in ms.
- `MIN_DWELL_MS`, 100: minimum time a committed mode is held, in ms.
- `clock` in 1: the single clock. All inputs are synchronous to it.
- `reset_n` in 1: asynchronous, active-low reset.
- `link_up` in 1: level, Ethernet link present.
- `dhcp_busy` in 1: level, DHCP negotiation in progress.
- `dhcp_fail` in 1: level, DHCP failed and a fallback IP is in use.
- `tx` in 1: level, transmitter keyed.
- `activity` in 1: one-cycle pulse per packet.
- `overload` in 1: one-cycle pulse per ADC overload.
- `on` out 1: to flasher, steady on.
- `slow_flash` out 1: to flasher, slow flash.
- `fast_flash` out 1: to flasher, fast flash.
- `vary` out 1: to flasher, alternating pattern.

## Operation
- **Prescaler:** a 25-bit counter runs 0..`CLOCK_SPEED/1000`−1 and emits `tick_ms` for one cycle at the terminal count, then wraps to 0.
- **Stretch timers:** two 16-bit down-counters, `act` and `ovl`.
  - An input pulse loads the hold value.
  - `tick_ms` decrements a nonzero count.
  - The timer is active while the count is ≠0.
  - A load and a tick on the same cycle: the load wins.
  - A retrigger while active reloads the full value.
  - Active time is from HOLD−1 ms to HOLD ms.
- **Requested mode:** combinational, highest priority first:
  - `ovl` active → FAST
  - `tx` → ON
  - `dhcp_fail` → VARY
  - `dhcp_busy` → SLOW
  - `act` active → ON
  - `link_up` → SLOW
  - otherwise → OFF
- **State machine:** states OFF, ON, SLOW, FAST, VARY, plus a 16-bit dwell counter.
  - When requested ≠ current and dwell = 0: the current mode takes the requested mode and dwell loads `MIN_DWELL_MS`.
  - Dwell decrements on `tick_ms` while nonzero.
  - A request that arrives during dwell is not queued. It is re-evaluated every cycle, and the request present when dwell reaches 0 is committed.
  - An entry into OFF also loads dwell.
- **Outputs:** a registered one-hot decode of the current mode; OFF gives all zeros. At most one output is high in any cycle.
- **Reset:** `reset_n` low clears the prescaler, both timers, dwell, and the current mode (OFF), and drives all outputs to 0 immediately. Assertion mid-operation aborts any stretch or dwell. Deassertion is followed by normal evaluation on the next edge.

## Timing
- **Level input change (dwell = 0):**
  - Cycle N: the input changes.
  - N+1: the current mode updates.
  - N+2: the outputs update.
- **Pulse input:** one extra cycle, for the timer load. A pulse at N shows on the outputs at N+3.
- **Mode-to-mode spacing:** output transitions are at least `MIN_DWELL_MS`·`CLOCK_SPEED/1000` cycles apart, minus up to one prescale period of quantisation.
- **Hold counters:** saturate at 0 and never wrap. A hold parameter of 0 disables that stretch (timer never active).
- **Prescaler:** the counter never exceeds its terminal value.

## Structure
- **Shared package `led_pkg`:**
  - mode enum `led_mode_t` as 3-bit: OFF=0, ON=1, SLOW=2, FAST=3, VARY=4
  - `MS_DIV` function
  - counter width constants (prescale 25, hold 16)
- **Sub-module `led_stretch`:** a retriggerable ms hold timer with ports `clock`, `reset_n`, `tick_ms`, `trig`, `active` and parameter `HOLD_MS`. It is instantiated twice, for `act` and `ovl`.
- **Top level:** the prescaler, the priority encoder, the dwell FSM and the output register stay here.

## Test plan
Benches run with `CLOCK_SPEED`=4000 (`tick_ms` every 4 cycles), `ACT_HOLD_MS`=3, `OVL_HOLD_MS`=5, `MIN_DWELL_MS`=2.
1. **Reset:** hold `reset_n` low with all inputs high → all outputs 0. Release → `fast_flash` is not high, because no overload has occurred, and `on`=1 (`tx`) is reached 2 cycles after the first edge.
2. **Link:** raise `link_up` at cycle 10 → `slow_flash`=1 at cycle 12. Drop `link_up` with dwell expired → all zero 2 cycles later.
3. **Activity stretch:** a single `activity` pulse with only `link_up` high → `on`=1 at +3 cycles, lasting 8–12 cycles, then back to `slow_flash` no sooner than the dwell allows. Back-to-back pulses every 4 cycles → `on` stays high continuously.
4. **Priority:** `overload` pulse while `dhcp_fail`=1 → `fast_flash` for the `ovl` hold, then `vary`. `tx` raised during `ovl` → remains `fast_flash`.
5. **Dwell:** toggle `dhcp_busy` every cycle for 40 cycles with `link_up`=1 → output transitions are ≥7 cycles apart and exactly one output is high throughout.
6. **Mid-operation reset:** assert `reset_n` low mid-stretch → outputs 0 asynchronously. After release with inputs idle → outputs stay 0 and no residual `on`.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the front-panel status LED arbiter.
// Holds the display mode encoding, counter widths and the ms divisor helper.
package led_pkg;

    typedef enum logic [2:0] {
        MODE_OFF  = 3'd0,
        MODE_ON   = 3'd1,
        MODE_SLOW = 3'd2,
        MODE_FAST = 3'd3,
        MODE_VARY = 3'd4
    } led_mode_t;

    localparam int PRESCALE_W = 25;
    localparam int HOLD_W     = 16;

    // Clock cycles per millisecond; the result must be at least 2.
    function automatic logic [PRESCALE_W-1:0] MS_DIV(input int clock_speed);
        int div;
        div = clock_speed / 1000;
        return div[PRESCALE_W-1:0];
    endfunction

endpackage

// File: rtl/led_stretch.sv
// led_stretch: retriggerable millisecond hold timer for single-cycle events.
// Ports: clock, reset_n (async low), tick_ms, trig (pulse), active (count != 0).
module led_stretch #(
    parameter int HOLD_MS = 50
) (
    input  logic clock,
    input  logic reset_n,
    input  logic tick_ms,
    input  logic trig,
    output logic active
);
    import led_pkg::*;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_MS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] count;

    // A trigger always reloads the full hold, even if a tick lands on the
    // same cycle, so the event is visible for HOLD-1 to HOLD ms.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (trig) begin
            count <= HOLD_LOAD;
        end else if (tick_ms && (count != '0)) begin
            count <= count - HOLD_ONE;
        end
    end

    assign active = (count != '0);

endmodule

// File: rtl/led_status_arbiter.sv
// led_status_arbiter: maps board status to one LED mode with dwell control.
// Ports: clock, reset_n, link_up, dhcp_busy, dhcp_fail, tx, activity, overload
// in; on, slow_flash, fast_flash, vary out (registered, at most one high).
module led_status_arbiter #(
    parameter int CLOCK_SPEED  = 25_000_000,
    parameter int ACT_HOLD_MS  = 50,
    parameter int OVL_HOLD_MS  = 500,
    parameter int MIN_DWELL_MS = 100
) (
    input  logic clock,
    input  logic reset_n,
    input  logic link_up,
    input  logic dhcp_busy,
    input  logic dhcp_fail,
    input  logic tx,
    input  logic activity,
    input  logic overload,
    output logic on,
    output logic slow_flash,
    output logic fast_flash,
    output logic vary
);
    import led_pkg::*;

    localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] PRE_LAST = MS_DIV(CLOCK_SPEED) - PRE_ONE;
    localparam logic [HOLD_W-1:0]     DWELL_LOAD = HOLD_W'(MIN_DWELL_MS);
    localparam logic [HOLD_W-1:0]     DWELL_ONE  = HOLD_W'(1);

    logic [PRESCALE_W-1:0] prescale;
    logic                  tick_ms;
    logic                  act_active;
    logic                  ovl_active;
    led_mode_t             req_mode;
    led_mode_t             cur_mode;
    logic [HOLD_W-1:0]     dwell;

    // Millisecond prescaler; tick_ms marks the terminal count.
    assign tick_ms = (prescale == PRE_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= '0;
        end else if (tick_ms) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PRE_ONE;
        end
    end

    led_stretch #(
        .HOLD_MS (ACT_HOLD_MS)
    ) u_act (
        .clock   (clock),
        .reset_n (reset_n),
        .tick_ms (tick_ms),
        .trig    (activity),
        .active  (act_active)
    );

    led_stretch #(
        .HOLD_MS (OVL_HOLD_MS)
    ) u_ovl (
        .clock   (clock),
        .reset_n (reset_n),
        .tick_ms (tick_ms),
        .trig    (overload),
        .active  (ovl_active)
    );

    // Fixed priority: overload beats a keyed transmitter, DHCP trouble
    // beats packet activity, and the link level is the background state.
    always_comb begin
        req_mode = MODE_OFF;
        priority case (1'b1)
            ovl_active: req_mode = MODE_FAST;
            tx:         req_mode = MODE_ON;
            dhcp_fail:  req_mode = MODE_VARY;
            dhcp_busy:  req_mode = MODE_SLOW;
            act_active: req_mode = MODE_ON;
            link_up:    req_mode = MODE_SLOW;
            default:    req_mode = MODE_OFF;
        endcase
    end

    // Dwell FSM: a mode change is only taken once dwell has run out; the
    // request is sampled live, so whatever is asked for then wins.
    // The output register decodes the previous cycle's committed mode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_mode   <= MODE_OFF;
            dwell      <= '0;
            on         <= 1'b0;
            slow_flash <= 1'b0;
            fast_flash <= 1'b0;
            vary       <= 1'b0;
        end else begin
            if ((req_mode != cur_mode) && (dwell == '0)) begin
                cur_mode <= req_mode;
                dwell    <= DWELL_LOAD;
            end else if (tick_ms && (dwell != '0)) begin
                dwell <= dwell - DWELL_ONE;
            end
            on         <= (cur_mode == MODE_ON);
            slow_flash <= (cur_mode == MODE_SLOW);
            fast_flash <= (cur_mode == MODE_FAST);
            vary       <= (cur_mode == MODE_VARY);
        end
    end

endmodule

// File: tb/tb_led_status_arbiter.sv
// tb_led_status_arbiter: directed scenario bench for led_status_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_status_arbiter;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic link_up = 1'b0;
    logic dhcp_busy = 1'b0;
    logic dhcp_fail = 1'b0;
    logic tx = 1'b0;
    logic activity = 1'b0;
    logic overload = 1'b0;
    logic on;
    logic slow_flash;
    logic fast_flash;
    logic vary;
    logic [3:0] outs;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [3:0] O_OFF  = 4'b0000;
    localparam logic [3:0] O_ON   = 4'b1000;
    localparam logic [3:0] O_SLOW = 4'b0100;
    localparam logic [3:0] O_FAST = 4'b0010;
    localparam logic [3:0] O_VARY = 4'b0001;

    assign outs = {on, slow_flash, fast_flash, vary};

    always #5 clock = ~clock;

    led_status_arbiter #(
        .CLOCK_SPEED  (4000),
        .ACT_HOLD_MS  (3),
        .OVL_HOLD_MS  (5),
        .MIN_DWELL_MS (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .link_up    (link_up),
        .dhcp_busy  (dhcp_busy),
        .dhcp_fail  (dhcp_fail),
        .tx         (tx),
        .activity   (activity),
        .overload   (overload),
        .on         (on),
        .slow_flash (slow_flash),
        .fast_flash (fast_flash),
        .vary       (vary)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic go_idle();
        link_up = 0; dhcp_busy = 0; dhcp_fail = 0;
        tx = 0; activity = 0; overload = 0;
        cyc(30);
    endtask

    task automatic test_reset();
        reset_n = 0;
        link_up = 1; dhcp_busy = 1; dhcp_fail = 1;
        tx = 1; activity = 1; overload = 1;
        cyc(3);
        total_cnt++;
        if (outs !== O_OFF) $display("FAIL reset_hold: got %b expected %b", outs, O_OFF);
        else pass_cnt++;
        activity = 0; overload = 0;
        reset_n = 1;
        cyc(1);
        total_cnt++;
        if (outs !== O_OFF) $display("FAIL reset_edge1: got %b expected %b", outs, O_OFF);
        else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (outs !== O_ON) $display("FAIL reset_tx_on: got %b expected %b", outs, O_ON);
        else pass_cnt++;
        cyc(20);
        total_cnt++;
        if (outs !== O_ON) $display("FAIL reset_no_fast: got %b expected %b", outs, O_ON);
        else pass_cnt++;
        go_idle();
    endtask

    task automatic test_link();
        link_up = 1;
        cyc(1);
        total_cnt++;
        if (outs !== O_OFF) $display("FAIL link_rise_n1: got %b expected %b", outs, O_OFF);
        else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (outs !== O_SLOW) $display("FAIL link_rise_n2: got %b expected %b", outs, O_SLOW);
        else pass_cnt++;
        cyc(10);
        link_up = 0;
        cyc(1);
        total_cnt++;
        if (outs !== O_SLOW) $display("FAIL link_fall_n1: got %b expected %b", outs, O_SLOW);
        else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (outs !== O_OFF) $display("FAIL link_fall_n2: got %b expected %b", outs, O_OFF);
        else pass_cnt++;
        cyc(12);
    endtask

    task automatic test_activity();
        int dur;
        int on_low;
        link_up = 1;
        cyc(12);
        total_cnt++;
        if (outs !== O_SLOW) $display("FAIL act_base: got %b expected %b", outs, O_SLOW);
        else pass_cnt++;
        activity = 1;
        cyc(1);
        activity = 0;
        cyc(1);
        total_cnt++;
        if (outs !== O_SLOW) $display("FAIL act_n2: got %b expected %b", outs, O_SLOW);
        else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (outs !== O_ON) $display("FAIL act_n3: got %b expected %b", outs, O_ON);
        else pass_cnt++;
        dur = 1;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (on !== 1'b1) break;
            dur++;
        end
        total_cnt++;
        if (dur < 8 || dur > 12) $display("FAIL act_len: got %0d cycles expected 8..12", dur);
        else pass_cnt++;
        total_cnt++;
        if (outs !== O_SLOW) $display("FAIL act_return: got %b expected %b", outs, O_SLOW);
        else pass_cnt++;
        cyc(12);
        // Pulses every 4 cycles retrigger before the stretch can lapse.
        on_low = 0;
        for (int k = 0; k < 6; k++) begin
            activity = 1;
            cyc(1);
            activity = 0;
            for (int j = 1; j < 4; j++) begin
                cyc(1);
                if ((4 * k + 1 + j) >= 3 && on !== 1'b1) on_low++;
            end
        end
        for (int j = 0; j < 7; j++) begin
            cyc(1);
            if (on !== 1'b1) on_low++;
        end
        total_cnt++;
        if (on_low !== 0) $display("FAIL act_b2b: got %0d low cycles expected 0", on_low);
        else pass_cnt++;
        go_idle();
    endtask

    task automatic test_priority();
        int dur;
        dhcp_fail = 1;
        cyc(12);
        total_cnt++;
        if (outs !== O_VARY) $display("FAIL pri_vary: got %b expected %b", outs, O_VARY);
        else pass_cnt++;
        overload = 1;
        cyc(1);
        overload = 0;
        cyc(2);
        total_cnt++;
        if (outs !== O_FAST) $display("FAIL pri_fast: got %b expected %b", outs, O_FAST);
        else pass_cnt++;
        dur = 1;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (fast_flash !== 1'b1) break;
            dur++;
        end
        total_cnt++;
        if (dur < 16 || dur > 20) $display("FAIL pri_fast_len: got %0d cycles expected 16..20", dur);
        else pass_cnt++;
        total_cnt++;
        if (outs !== O_VARY) $display("FAIL pri_back_vary: got %b expected %b", outs, O_VARY);
        else pass_cnt++;
        cyc(12);
        overload = 1;
        cyc(1);
        overload = 0;
        cyc(2);
        total_cnt++;
        if (outs !== O_FAST) $display("FAIL pri_fast2: got %b expected %b", outs, O_FAST);
        else pass_cnt++;
        tx = 1;
        cyc(5);
        total_cnt++;
        if (outs !== O_FAST) $display("FAIL pri_tx_masked: got %b expected %b", outs, O_FAST);
        else pass_cnt++;
        dur = 6;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (fast_flash !== 1'b1) break;
            dur++;
        end
        total_cnt++;
        if (dur < 16 || dur > 20) $display("FAIL pri_fast2_len: got %0d cycles expected 16..20", dur);
        else pass_cnt++;
        total_cnt++;
        if (outs !== O_ON) $display("FAIL pri_tx_after: got %b expected %b", outs, O_ON);
        else pass_cnt++;
        go_idle();
    endtask

    task automatic test_dwell();
        int bad;
        int last_t;
        int min_gap;
        int trans;
        logic [3:0] prev;
        link_up = 1;
        cyc(12);
        // dhcp_busy and link_up both ask for SLOW: nothing should move.
        bad = 0; last_t = -1; min_gap = 1000; trans = 0; prev = outs;
        for (int i = 0; i < 40; i++) begin
            dhcp_busy = ~dhcp_busy;
            cyc(1);
            if ($countones(outs) != 1) bad++;
            if (outs !== prev) begin
                trans++;
                if (last_t >= 0 && (i - last_t) < min_gap) min_gap = i - last_t;
                last_t = i;
            end
            prev = outs;
        end
        dhcp_busy = 0;
        total_cnt++;
        if (bad !== 0) $display("FAIL dwell_busy_onehot: got %0d bad cycles expected 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (min_gap < 7) $display("FAIL dwell_busy_gap: got %0d expected >=7", min_gap);
        else pass_cnt++;
        cyc(12);
        // dhcp_fail toggling flips the request between VARY and SLOW.
        bad = 0; last_t = -1; min_gap = 1000; trans = 0; prev = outs;
        for (int i = 0; i < 40; i++) begin
            dhcp_fail = ~dhcp_fail;
            cyc(1);
            if ($countones(outs) != 1) bad++;
            if (outs !== prev) begin
                trans++;
                if (last_t >= 0 && (i - last_t) < min_gap) min_gap = i - last_t;
                last_t = i;
            end
            prev = outs;
        end
        dhcp_fail = 0;
        total_cnt++;
        if (bad !== 0) $display("FAIL dwell_fail_onehot: got %0d bad cycles expected 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (min_gap < 4) $display("FAIL dwell_fail_gap: got %0d expected >=4", min_gap);
        else pass_cnt++;
        total_cnt++;
        if (trans < 3) $display("FAIL dwell_fail_moves: got %0d transitions expected >=3", trans);
        else pass_cnt++;
        go_idle();
    endtask

    task automatic test_mid_reset();
        int bad;
        link_up = 1;
        cyc(12);
        activity = 1;
        cyc(1);
        activity = 0;
        cyc(3);
        total_cnt++;
        if (outs !== O_ON) $display("FAIL mrst_pre: got %b expected %b", outs, O_ON);
        else pass_cnt++;
        #2;
        reset_n = 0;
        #1;
        total_cnt++;
        if (outs !== O_OFF) $display("FAIL mrst_async: got %b expected %b", outs, O_OFF);
        else pass_cnt++;
        link_up = 0;
        cyc(2);
        reset_n = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (outs !== O_OFF) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL mrst_residual: got %0d nonzero cycles expected 0", bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_link();
        test_activity();
        test_priority();
        test_dwell();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
